// File: rtl/mod_arith_pipe.sv
// mod_arith_pipe -- pipelined modular ALU for Kyber coefficient arithmetic (q = 3329).
//
// Runs one operation per cycle with a fixed three-stage pipeline:
//   00 ADD  (a + b) mod Q
//   01 SUB  (a - b) mod Q
//   10 MUL  Montgomery product a * b * 2^-RBITS mod Q
//   11 PASS returns a
// The whole pipeline advances when the output slot is empty or is being drained.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready is combinational from out_ready
//   in_op, in_a, in_b     opcode and operands (operands expected < Q)
//   in_tag                opaque tag carried alongside the op
//   out_valid / out_ready output handshake
//   out_res, out_tag      result in [0,Q) for in-range operands, and the tag of its op
//   out_err               operand-range flag (tied 0 unless the macro below is defined)
// Build option: MOD_ARITH_RANGE_CHECK_EN adds a flag on ops whose operands are >= Q.
module mod_arith_pipe #(
   parameter int unsigned DWIDTH    = 12,
   parameter int unsigned Q         = 3329,
   parameter int unsigned RBITS     = 16,
   parameter int unsigned QPRIME    = 3327,
   parameter int unsigned TAG_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_op,
   input  logic [DWIDTH-1:0]    in_a,
   input  logic [DWIDTH-1:0]    in_b,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DWIDTH-1:0]    out_res,
   output logic [TAG_WIDTH-1:0] out_tag,
   output logic                 out_err
);

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_PASS = 2'b11
   } op_e;

   // Width of p + t*Q; the reduced value u = (p + t*Q) >> RBITS is below 2Q.
   localparam int unsigned MW = RBITS + DWIDTH + 2;
   localparam int unsigned UW = MW - RBITS;

   localparam logic [DWIDTH:0]  Q_S  = (DWIDTH+1)'(Q);
   localparam logic [RBITS-1:0] QP_R = RBITS'(QPRIME);
   localparam logic [MW-1:0]    Q_M  = MW'(Q);
   localparam logic [UW-1:0]    Q_U  = UW'(Q);

   logic adv;

   // Stage 1: registered op
   logic                 s1_valid_q;
   op_e                  s1_op_q;
   logic [DWIDTH-1:0]    s1_a_q, s1_b_q;
   logic [TAG_WIDTH-1:0] s1_tag_q;

   // Stage 2: partial results
   logic                 s2_valid_q;
   op_e                  s2_op_q;
   logic [TAG_WIDTH-1:0] s2_tag_q;
   logic [DWIDTH:0]      s2_r_q;      // sum (ADD), difference (SUB) or a (PASS)
   logic [2*DWIDTH-1:0]  s2_p_q;
   logic [RBITS-1:0]     s2_t_q;

   // Stage 3: output registers
   logic                 out_valid_q;
   logic [DWIDTH-1:0]    out_res_q;
   logic [TAG_WIDTH-1:0] out_tag_q;

   logic [DWIDTH:0]      r_d;
   logic [2*DWIDTH-1:0]  p_d;
   logic [RBITS-1:0]     t_d;
   logic [MW-1:0]        mred_d;
   logic [UW-1:0]        u_d;
   logic [DWIDTH-1:0]    res_d;

   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   // Stage 2 arithmetic
   assign p_d = s1_a_q * s1_b_q;
   assign t_d = p_d[RBITS-1:0] * QP_R;   // only the low RBITS bits of the product are kept

   always_comb begin
      r_d = '0;
      unique case (s1_op_q)
         OP_ADD:  r_d = {1'b0, s1_a_q} + {1'b0, s1_b_q};
         OP_SUB:  r_d = (s1_a_q < s1_b_q) ? ({1'b0, s1_a_q} + Q_S - {1'b0, s1_b_q})
                                          : ({1'b0, s1_a_q} - {1'b0, s1_b_q});
         default: r_d = {1'b0, s1_a_q};
      endcase
   end

   // Stage 3: Montgomery reduction and final conditional subtraction
   assign mred_d = MW'(s2_p_q) + MW'(s2_t_q) * Q_M;
   assign u_d    = UW'(mred_d >> RBITS);

   always_comb begin
      res_d = '0;
      unique case (s2_op_q)
         OP_ADD:  res_d = DWIDTH'((s2_r_q >= Q_S) ? (s2_r_q - Q_S) : s2_r_q);
         OP_MUL:  res_d = DWIDTH'((u_d >= Q_U) ? (u_d - Q_U) : u_d);
         default: res_d = s2_r_q[DWIDTH-1:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= OP_ADD;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_op_q     <= OP_ADD;
         s2_tag_q    <= '0;
         s2_r_q      <= '0;
         s2_p_q      <= '0;
         s2_t_q      <= '0;
         out_valid_q <= 1'b0;
         out_res_q   <= '0;
         out_tag_q   <= '0;
      end else if (adv) begin
         s1_valid_q  <= in_valid;
         s1_op_q     <= op_e'(in_op);
         s1_a_q      <= in_a;
         s1_b_q      <= in_b;
         s1_tag_q    <= in_tag;
         s2_valid_q  <= s1_valid_q;
         s2_op_q     <= s1_op_q;
         s2_tag_q    <= s1_tag_q;
         s2_r_q      <= r_d;
         s2_p_q      <= p_d;
         s2_t_q      <= t_d;
         out_valid_q <= s2_valid_q;
         // Result and tag keep their last value across bubbles
         if (s2_valid_q) begin
            out_res_q <= res_d;
            out_tag_q <= s2_tag_q;
         end
      end
   end

`ifdef MOD_ARITH_RANGE_CHECK_EN
   logic s1_err_q, s2_err_q, out_err_q;
   logic err_d;

   assign err_d = (in_a >= DWIDTH'(Q)) ||
                  ((op_e'(in_op) != OP_PASS) && (in_b >= DWIDTH'(Q)));

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_err_q  <= 1'b0;
         s2_err_q  <= 1'b0;
         out_err_q <= 1'b0;
      end else if (adv) begin
         s1_err_q  <= err_d;
         s2_err_q  <= s1_err_q;
         out_err_q <= s2_valid_q && s2_err_q;
      end
   end

   assign out_err = out_err_q;
`else
   assign out_err = 1'b0;
`endif

   assign out_valid = out_valid_q;
   assign out_res   = out_res_q;
   assign out_tag   = out_tag_q;

endmodule
